// File: rtl/sata_cmd_scheduler.sv
// sata_cmd_scheduler
// Shares the sata_stack command interface between two requesters using
// round-robin arbitration. Each request is split into stack commands of at
// most MAX_SECTORS sectors. Every wait on the stack is covered by a watchdog,
// and a watchdog expiry triggers a stack soft reset.
// Optional build macro: SATA_SCHED_RETRY_EN (reissue a failed chunk once).

module sata_cmd_scheduler #(
   parameter logic [15:0] MAX_SECTORS    = 16'd256,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sata_ready,
   input  logic        busy,
   input  logic [7:0]  d2h_status,
   input  logic [7:0]  d2h_error,
   output logic        write_data_en,
   output logic        read_data_en,
   output logic        single_rdwr,
   output logic        soft_reset_en,
   output logic [15:0] sector_count,
   output logic [47:0] sector_address,
   input  logic        req0,
   input  logic        req1,
   input  logic        wr0,
   input  logic        wr1,
   input  logic [23:0] count0,
   input  logic [23:0] count1,
   input  logic [47:0] lba0,
   input  logic [47:0] lba1,
   output logic        ack0,
   output logic        ack1,
   output logic        done0,
   output logic        done1,
   output logic        err0,
   output logic        err1,
   output logic [7:0]  err_code,
   output logic        active,
   output logic        owner
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_CHUNK,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_CHECK,
      S_RESET_DEV,
      S_RESET_WAIT,
      S_FINISH
   } state_t;

   state_t      state;
   state_t      next_state;

   logic [23:0] wd_cnt;
   logic        wd_counting;
   logic        timeout;

   logic        rr_prefer;
   logic        wr_q;
   logic        err_q;
   logic [23:0] remaining;
   logic [47:0] cur_lba;
   logic [15:0] chunk_len;

   logic        grant;
   logic        grant_port;
   logic        load_chunk;
   logic        chunk_ok;
   logic        fail;
   logic [7:0]  fail_code;
   logic        finish_err;
   logic        en_level;

   // Only the ERR bit of the status register matters here.
   logic        unused_status;
   assign unused_status = ^d2h_status[7:1];

`ifdef SATA_SCHED_RETRY_EN
   logic        retry_used;
   logic        retry_take;
`endif

   assign chunk_len   = (remaining > {8'd0, MAX_SECTORS}) ? MAX_SECTORS : remaining[15:0];
   assign wd_counting = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE) || (state == S_RESET_WAIT);
   assign timeout     = wd_counting && (wd_cnt >= (TIMEOUT_CYCLES - 24'd1));

   // Next-state logic, arbitration and per-state control strobes.
   always_comb begin
      next_state = state;
      grant      = 1'b0;
      grant_port = 1'b0;
      load_chunk = 1'b0;
      chunk_ok   = 1'b0;
      fail       = 1'b0;
      fail_code  = 8'h00;
      finish_err = 1'b0;
`ifdef SATA_SCHED_RETRY_EN
      retry_take = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (sata_ready && !busy && (req0 || req1)) begin
               grant      = 1'b1;
               grant_port = (req0 && req1) ? rr_prefer : req1;
               next_state = S_CHUNK;
            end
         end
         S_CHUNK: begin
            if (remaining == 24'd0) begin
               next_state = S_FINISH;
            end else begin
               load_chunk = 1'b1;
               next_state = S_ISSUE;
            end
         end
         S_ISSUE: begin
            next_state = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (busy) begin
               next_state = S_WAIT_DONE;
            end else if (timeout) begin
               fail       = 1'b1;
               fail_code  = 8'hFF;
               next_state = S_RESET_DEV;
            end
         end
         S_WAIT_DONE: begin
            if (!busy) begin
               next_state = S_CHECK;
            end else if (timeout) begin
               fail       = 1'b1;
               fail_code  = 8'hFF;
               next_state = S_RESET_DEV;
            end
         end
         S_CHECK: begin
            if (d2h_status[0]) begin
               fail      = 1'b1;
               fail_code = d2h_error;
`ifdef SATA_SCHED_RETRY_EN
               if (!retry_used) begin
                  retry_take = 1'b1;
                  next_state = S_ISSUE;
               end else begin
                  finish_err = 1'b1;
                  next_state = S_FINISH;
               end
`else
               finish_err = 1'b1;
               next_state = S_FINISH;
`endif
            end else begin
               chunk_ok   = 1'b1;
               next_state = S_CHUNK;
            end
         end
         S_RESET_DEV: begin
            next_state = S_RESET_WAIT;
         end
         S_RESET_WAIT: begin
            if (sata_ready && !busy) begin
`ifdef SATA_SCHED_RETRY_EN
               if (!retry_used) begin
                  retry_take = 1'b1;
                  next_state = S_ISSUE;
               end else begin
                  finish_err = 1'b1;
                  next_state = S_FINISH;
               end
`else
               finish_err = 1'b1;
               next_state = S_FINISH;
`endif
            end else if (timeout) begin
               finish_err = 1'b1;
               next_state = S_FINISH;
            end
         end
         S_FINISH: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // State register, watchdog, latched request and chunk bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         wd_cnt         <= 24'd0;
         rr_prefer      <= 1'b0;
         owner          <= 1'b0;
         active         <= 1'b0;
         ack0           <= 1'b0;
         ack1           <= 1'b0;
         wr_q           <= 1'b0;
         err_q          <= 1'b0;
         err_code       <= 8'h00;
         remaining      <= 24'd0;
         cur_lba        <= 48'd0;
         sector_count   <= 16'd0;
         sector_address <= 48'd0;
      end else begin
         state  <= next_state;
         ack0   <= grant && !grant_port;
         ack1   <= grant && grant_port;
         active <= (next_state != S_IDLE) && (next_state != S_FINISH);

         if (next_state != state) begin
            wd_cnt <= 24'd0;
         end else if (wd_counting) begin
            wd_cnt <= wd_cnt + 24'd1;
         end

         if (grant) begin
            owner     <= grant_port;
            rr_prefer <= !grant_port;
            wr_q      <= grant_port ? wr1 : wr0;
            remaining <= grant_port ? count1 : count0;
            cur_lba   <= grant_port ? lba1 : lba0;
            err_q     <= 1'b0;
            err_code  <= 8'h00;
         end

         if (load_chunk) begin
            sector_count   <= chunk_len;
            sector_address <= cur_lba;
         end

         if (chunk_ok) begin
            remaining <= remaining - {8'd0, sector_count};
            cur_lba   <= cur_lba + {32'd0, sector_count};
         end

         if (fail) begin
            err_code <= fail_code;
         end

         if (finish_err) begin
            err_q <= 1'b1;
         end
      end
   end

`ifdef SATA_SCHED_RETRY_EN
   // One retry per chunk; the flag rearms on a successful chunk or a new grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retry_used <= 1'b0;
      end else if (grant || chunk_ok) begin
         retry_used <= 1'b0;
      end else if (retry_take) begin
         retry_used <= 1'b1;
      end
   end
`endif

   // Enable is held from ISSUE until busy is seen, and dropped on watchdog expiry.
   assign en_level       = (state == S_ISSUE) || ((state == S_WAIT_BUSY) && !busy && !timeout);
   assign write_data_en  = en_level && wr_q;
   assign read_data_en   = en_level && !wr_q;
   assign single_rdwr    = 1'b0;
   assign soft_reset_en  = (state == S_RESET_DEV);
   assign done0          = (state == S_FINISH) && !owner;
   assign done1          = (state == S_FINISH) && owner;
   assign err0           = done0 && err_q;
   assign err1           = done1 && err_q;

endmodule

// File: tb/tb_sata_cmd_scheduler.sv
// tb_sata_cmd_scheduler
// Directed bench for sata_cmd_scheduler with a small behavioural stack model.
// Expectations follow SATA_SCHED_RETRY_EN when it is defined for the build.

module tb_sata_cmd_scheduler;

   logic        clk;
   logic        rst_n;
   logic        sata_ready;
   logic        busy;
   logic [7:0]  d2h_status;
   logic [7:0]  d2h_error;
   logic        write_data_en;
   logic        read_data_en;
   logic        single_rdwr;
   logic        soft_reset_en;
   logic [15:0] sector_count;
   logic [47:0] sector_address;
   logic        req0, req1, wr0, wr1;
   logic [23:0] count0, count1;
   logic [47:0] lba0, lba1;
   logic        ack0, ack1, done0, done1, err0, err1;
   logic [7:0]  err_code;
   logic        active;
   logic        owner;

   int checks;
   int failures;
   int cyc;

   logic [47:0] cmd_addr[$];
   logic [15:0] cmd_cnt[$];
   logic        cmd_wr[$];
   int          cmd_cyc[$];
   int          ack_order[$];

   int          n_ack0, n_ack1, n_done0, n_done1, n_soft;
   int          ack0_cyc, done0_cyc, soft_cyc;
   logic        last_err0, last_err1, en_at_soft;
   logic [7:0]  code_at_done;
   bit          both_seen;

   int          phase;
   int          hold;
   bit          stuck;
   bit          stuck_next;
   int          err_budget;

   int          b;
   int          k;
   int          a0;
   int          d0;
   int          s0;

   sata_cmd_scheduler #(
      .MAX_SECTORS    (16'd256),
      .TIMEOUT_CYCLES (24'd100)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .sata_ready     (sata_ready),
      .busy           (busy),
      .d2h_status     (d2h_status),
      .d2h_error      (d2h_error),
      .write_data_en  (write_data_en),
      .read_data_en   (read_data_en),
      .single_rdwr    (single_rdwr),
      .soft_reset_en  (soft_reset_en),
      .sector_count   (sector_count),
      .sector_address (sector_address),
      .req0           (req0),
      .req1           (req1),
      .wr0            (wr0),
      .wr1            (wr1),
      .count0         (count0),
      .count1         (count1),
      .lba0           (lba0),
      .lba1           (lba1),
      .ack0           (ack0),
      .ack1           (ack1),
      .done0          (done0),
      .done1          (done1),
      .err0           (err0),
      .err1           (err1),
      .err_code       (err_code),
      .active         (active),
      .owner          (owner)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Event monitor plus behavioural stack, both sampled on the falling edge.
   initial begin
      cyc = 0; n_ack0 = 0; n_ack1 = 0; n_done0 = 0; n_done1 = 0; n_soft = 0;
      ack0_cyc = 0; done0_cyc = 0; soft_cyc = 0;
      last_err0 = 1'b0; last_err1 = 1'b0; en_at_soft = 1'b0; code_at_done = 8'h00;
      both_seen = 1'b0;
      busy = 1'b0; d2h_status = 8'h50; d2h_error = 8'h00;
      phase = 0; hold = 0; stuck = 1'b0; stuck_next = 1'b0; err_budget = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (ack0) begin n_ack0++; ack0_cyc = cyc; ack_order.push_back(0); end
         if (ack1) begin n_ack1++; ack_order.push_back(1); end
         if (done0) begin n_done0++; done0_cyc = cyc; last_err0 = err0; code_at_done = err_code; end
         if (done1) begin n_done1++; last_err1 = err1; code_at_done = err_code; end
         if (soft_reset_en) begin n_soft++; soft_cyc = cyc; en_at_soft = write_data_en | read_data_en; end
         if (write_data_en && read_data_en) both_seen = 1'b1;
         if (!rst_n) begin
            busy = 1'b0; phase = 0; stuck = 1'b0;
         end else if (phase == 0) begin
            if (write_data_en || read_data_en) begin
               cmd_addr.push_back(sector_address);
               cmd_cnt.push_back(sector_count);
               cmd_wr.push_back(write_data_en);
               cmd_cyc.push_back(cyc);
               busy = 1'b1; hold = 3; stuck = stuck_next; stuck_next = 1'b0; phase = 1;
            end
         end else begin
            if (soft_reset_en) begin
               stuck = 1'b0; hold = 2;
            end else if (!stuck) begin
               hold--;
               if (hold == 0) begin
                  busy = 1'b0;
                  if (err_budget > 0) begin
                     err_budget--; d2h_status = 8'h51; d2h_error = 8'h04;
                  end else begin
                     d2h_status = 8'h50; d2h_error = 8'h00;
                  end
                  phase = 0;
               end
            end
         end
      end
   end

   // Counts one comparison and reports it when the values differ.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drives one requester's inputs.
   task automatic applyStimulus(input bit port, input bit wr, input logic [23:0] cnt,
                                input logic [47:0] lba, input bit req);
      if (port) begin
         wr1 = wr; count1 = cnt; lba1 = lba; req1 = req;
      end else begin
         wr0 = wr; count0 = cnt; lba0 = lba; req0 = req;
      end
   endtask

   // Pulses reset and releases it away from the clock edge.
   task automatic doReset();
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
   endtask

   // Issues one request, drops req on ack and waits (bounded) for its done.
   task automatic runRequest(input bit port, input bit wr, input logic [23:0] cnt, input logic [47:0] lba);
      int dd, aa, n;
      dd = port ? n_done1 : n_done0;
      aa = port ? n_ack1 : n_ack0;
      applyStimulus(port, wr, cnt, lba, 1'b1);
      n = 0;
      while (((port ? n_done1 : n_done0) == dd) && n < 3000) begin
         @(negedge clk); #1; n++;
         if ((port ? n_ack1 : n_ack0) != aa) begin
            if (port) req1 = 1'b0; else req0 = 1'b0;
         end
      end
      checkOutput("req_done_seen", 64'(n < 3000), 1);
   endtask

   // Asserts both requesters together and checks the grant order.
   task automatic pairRound(input bit first);
      int qa, dd0, dd1, n;
      qa = ack_order.size(); dd0 = n_done0; dd1 = n_done1;
      applyStimulus(1'b0, 1'b0, 24'd1, 48'h10, 1'b1);
      applyStimulus(1'b1, 1'b0, 24'd1, 48'h20, 1'b1);
      n = 0;
      while ((n_done0 == dd0 || n_done1 == dd1) && n < 3000) begin
         @(negedge clk); #1; n++;
         if (ack_order.size() > qa) begin
            if (ack_order[qa] == 0) req0 = 1'b0; else req1 = 1'b0;
         end
         if (ack_order.size() > qa + 1) begin
            if (ack_order[qa + 1] == 0) req0 = 1'b0; else req1 = 1'b0;
         end
      end
      checkOutput("rr_both_done", 64'(n < 3000), 1);
      checkOutput("rr_first", 64'(ack_order[qa]), 64'(first));
      checkOutput("rr_second", 64'(ack_order[qa + 1]), 64'(!first));
   endtask

   // Directed test sequence.
   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b0; sata_ready = 1'b1;
      req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
      count0 = 24'd0; count1 = 24'd0; lba0 = 48'd0; lba1 = 48'd0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_outputs",
                  {write_data_en, read_data_en, single_rdwr, soft_reset_en, ack0, ack1,
                   done0, done1, err0, err1, active, owner}, 12'h000);
      checkOutput("reset_sector", {sector_count, sector_address}, 64'd0);
      checkOutput("reset_err_code", err_code, 8'h00);
      @(negedge clk); #1 rst_n = 1'b1;
      repeat (2) @(negedge clk); #1;

      $display("[TB] multi-chunk write");
      b = cmd_addr.size();
      runRequest(1'b0, 1'b1, 24'd600, 48'h1000);
      checkOutput("t1_ncmd", 64'(cmd_addr.size() - b), 3);
      checkOutput("t1_addr0", cmd_addr[b], 48'h1000);
      checkOutput("t1_addr1", cmd_addr[b + 1], 48'h1100);
      checkOutput("t1_addr2", cmd_addr[b + 2], 48'h1200);
      checkOutput("t1_cnt0", cmd_cnt[b], 16'd256);
      checkOutput("t1_cnt1", cmd_cnt[b + 1], 16'd256);
      checkOutput("t1_cnt2", cmd_cnt[b + 2], 16'd88);
      checkOutput("t1_wr", {cmd_wr[b], cmd_wr[b + 1], cmd_wr[b + 2]}, 3'b111);
      checkOutput("t1_err", last_err0, 1'b0);
      checkOutput("t1_latency", 64'(cmd_cyc[b] - ack0_cyc), 1);

      $display("[TB] round robin");
      doReset();
      pairRound(1'b0);
      pairRound(1'b0);
      runRequest(1'b0, 1'b0, 24'd1, 48'h30);
      pairRound(1'b1);

      $display("[TB] read with ERR status");
      b = cmd_addr.size();
      err_budget = 1;
      runRequest(1'b0, 1'b0, 24'd4, 48'h2000);
      checkOutput("t3_cnt", cmd_cnt[b], 16'd4);
      checkOutput("t3_rd", cmd_wr[b], 1'b0);
`ifdef SATA_SCHED_RETRY_EN
      checkOutput("t3_ncmd", 64'(cmd_addr.size() - b), 2);
      checkOutput("t3_retry_addr", cmd_addr[b + 1], 48'h2000);
      checkOutput("t3_err", last_err0, 1'b0);
`else
      checkOutput("t3_ncmd", 64'(cmd_addr.size() - b), 1);
      checkOutput("t3_err", last_err0, 1'b1);
      checkOutput("t3_code", code_at_done, 8'h04);
`endif

      $display("[TB] watchdog timeout");
      b = cmd_addr.size();
      s0 = n_soft;
      stuck_next = 1'b1;
      runRequest(1'b0, 1'b1, 24'd8, 48'h3000);
      checkOutput("t4_soft_pulses", 64'(n_soft - s0), 1);
      checkOutput("t4_soft_delay", 64'(soft_cyc - cmd_cyc[b]), 102);
      checkOutput("t4_en_at_soft", en_at_soft, 1'b0);
`ifdef SATA_SCHED_RETRY_EN
      checkOutput("t4_ncmd", 64'(cmd_addr.size() - b), 2);
      checkOutput("t4_retry_addr", cmd_addr[b + 1], 48'h3000);
      checkOutput("t4_err", last_err0, 1'b0);
`else
      checkOutput("t4_ncmd", 64'(cmd_addr.size() - b), 1);
      checkOutput("t4_err", last_err0, 1'b1);
      checkOutput("t4_code", code_at_done, 8'hFF);
`endif

      $display("[TB] zero-length request");
      b = cmd_addr.size();
      runRequest(1'b0, 1'b1, 24'd0, 48'h4000);
      checkOutput("t5_ncmd", 64'(cmd_addr.size() - b), 0);
      checkOutput("t5_done_delay", 64'(done0_cyc - ack0_cyc), 1);
      checkOutput("t5_err", last_err0, 1'b0);

      $display("[TB] LBA wrap");
      b = cmd_addr.size();
      runRequest(1'b1, 1'b0, 24'd258, 48'hFFFF_FFFF_FF00);
      checkOutput("t6_ncmd", 64'(cmd_addr.size() - b), 2);
      checkOutput("t6_addr0", cmd_addr[b], 48'hFFFF_FFFF_FF00);
      checkOutput("t6_addr1", cmd_addr[b + 1], 48'h0);
      checkOutput("t6_cnt1", cmd_cnt[b + 1], 16'd2);
      checkOutput("t6_err", last_err1, 1'b0);

      $display("[TB] reset during WAIT_DONE");
      b = cmd_addr.size();
      d0 = n_done0;
      a0 = n_ack0;
      stuck_next = 1'b1;
      applyStimulus(1'b0, 1'b0, 24'd1, 48'h77, 1'b1);
      k = 0;
      while (cmd_addr.size() == b && k < 100) begin
         @(negedge clk); #1; k++;
         if (n_ack0 != a0) req0 = 1'b0;
      end
      req0 = 1'b0;
      checkOutput("t7_cmd_issued", 64'(cmd_addr.size() - b), 1);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t7_async_outputs",
                  {write_data_en, read_data_en, single_rdwr, soft_reset_en, ack0, ack1,
                   done0, done1, err0, err1, active, owner}, 12'h000);
      checkOutput("t7_async_regs", {sector_count, sector_address}, 64'd0);
      repeat (10) @(negedge clk);
      #1;
      checkOutput("t7_no_done", 64'(n_done0 - d0), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      checkOutput("never_both_enables", both_seen, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
